// File: rtl/rans_mod_pkg.sv
// Shared types and defaults for the rANS modulo-unit scheduler.
// A 64-bit operand is carried as separate 32-bit high and low halves.
package rans_mod_pkg;

  localparam int DEFAULT_NREQ    = 4;
  localparam int DEFAULT_TIMEOUT = 255;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } sched_state_t;

  typedef struct packed {
    logic [31:0] high;
    logic [31:0] low;
  } u64_split_t;

endpackage

// File: rtl/rans_rr_arbiter.sv
// Combinational round-robin arbiter: the first asserted request at or after
// ptr wins, wrapping around to index 0.
module rans_rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         grant,
  output logic [$clog2(NREQ)-1:0] idx,
  output logic                    any
);

  localparam int IW = $clog2(NREQ);

  logic any_upper;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves a value held, which would infer a latch.
    any_upper = 1'b0;
    idx       = '0;
    grant     = '0;
    any       = |req;

    // Scan downwards so the last hit is the lowest index in the upper window.
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i] && (i >= int'(ptr))) begin
        any_upper = 1'b1;
        idx       = IW'(i);
      end
    end

    if (!any_upper) begin
      for (int i = NREQ - 1; i >= 0; i--) begin
        if (req[i]) idx = IW'(i);
      end
    end

    for (int i = 0; i < NREQ; i++) begin
      grant[i] = any && (idx == IW'(i));
    end
  end

endmodule

// File: rtl/rans_mod_scheduler.sv
// Shares one iterative 64-bit modulo unit between NREQ requesters, answering
// zero divisors locally and bounding the wait for the unit with a watchdog.
module rans_mod_scheduler
  import rans_mod_pkg::*;
#(
  parameter int NREQ    = DEFAULT_NREQ,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*32-1:0] req_x_high,
  input  logic [NREQ*32-1:0] req_x_low,
  input  logic [NREQ*32-1:0] req_z_high,
  input  logic [NREQ*32-1:0] req_z_low,
  output logic [NREQ-1:0]    rsp_valid,
  input  logic [NREQ-1:0]    rsp_ready,
  output logic [31:0]        rsp_high,
  output logic [31:0]        rsp_low,
  output logic               rsp_error,
  output logic               mod_start,
  output logic [31:0]        mod_x_high,
  output logic [31:0]        mod_x_low,
  output logic [31:0]        mod_z_high,
  output logic [31:0]        mod_z_low,
  input  logic               mod_valid,
  input  logic [31:0]        mod_high,
  input  logic [31:0]        mod_low
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT + 1);

  sched_state_t  state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] gnt_idx;
  logic [NREQ-1:0] gnt_oh;
  u64_split_t    op_x;
  u64_split_t    op_z;
  u64_split_t    result;
  logic [CW-1:0] wd_cnt;
  logic [CW-1:0] wd_next;

  logic [NREQ-1:0] arb_grant;
  logic [IW-1:0]   arb_idx;
  logic            arb_any;
  u64_split_t      sel_x;
  u64_split_t      sel_z;

  rans_rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  // One-hot operand mux keeps every part-select index constant.
  always_comb begin
    sel_x = '0;
    sel_z = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_grant[i]) begin
        sel_x = '{high: req_x_high[i*32 +: 32], low: req_x_low[i*32 +: 32]};
        sel_z = '{high: req_z_high[i*32 +: 32], low: req_z_low[i*32 +: 32]};
      end
    end
  end

  assign req_ready  = (state == IDLE && !reset) ? arb_grant : '0;
  assign wd_next    = wd_cnt + CW'(1);
  assign mod_x_high = op_x.high;
  assign mod_x_low  = op_x.low;
  assign mod_z_high = op_z.high;
  assign mod_z_low  = op_z.low;
  assign rsp_high   = result.high;
  assign rsp_low    = result.low;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= '0;
      gnt_idx   <= '0;
      gnt_oh    <= '0;
      op_x      <= '0;
      op_z      <= '0;
      result    <= '0;
      rsp_error <= 1'b0;
      rsp_valid <= '0;
      mod_start <= 1'b0;
      wd_cnt    <= '0;
    end else begin
      // NOTE: non-blocking assignments let this default be overridden later in the same block without races.
      mod_start <= 1'b0;
      case (state)
        IDLE: begin
          if (arb_any) begin
            gnt_idx <= arb_idx;
            gnt_oh  <= arb_grant;
            op_x    <= sel_x;
            op_z    <= sel_z;
            if (sel_z == '0) begin
              result    <= '0;
              rsp_error <= 1'b1;
              rsp_valid <= arb_grant;
              state     <= RESP;
            end else begin
              mod_start <= 1'b1;
              state     <= ISSUE;
            end
          end
        end
        ISSUE: begin
          wd_cnt <= '0;
          state  <= WAIT;
        end
        WAIT: begin
          // A result arriving on the last watchdog cycle still wins.
          if (mod_valid) begin
            result    <= '{high: mod_high, low: mod_low};
            rsp_error <= 1'b0;
            rsp_valid <= gnt_oh;
            state     <= RESP;
          end else if (wd_next == CW'(TIMEOUT)) begin
            result    <= '0;
            rsp_error <= 1'b1;
            rsp_valid <= gnt_oh;
            state     <= RESP;
          end else begin
            wd_cnt <= wd_next;
          end
        end
        RESP: begin
          if (|(rsp_valid & rsp_ready)) begin
            rsp_valid <= '0;
            ptr       <= (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + IW'(1);
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rans_mod_scheduler.sv
// Self-checking bench: a behavioural modulo unit drives the main instance,
// a second instance with a short watchdog exercises the timeout path.
module tb_rans_mod_scheduler;

  localparam int NREQ = 4;
  localparam int LAT  = 64;
  localparam int TO2  = 20;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  logic [NREQ-1:0]    req_valid = '0;
  logic [NREQ-1:0]    rsp_ready = '1;
  logic [NREQ*32-1:0] req_x_high = '0, req_x_low = '0, req_z_high = '0, req_z_low = '0;

  logic [NREQ-1:0] req_ready, rsp_valid;
  logic [31:0]     rsp_high, rsp_low;
  logic            rsp_error, mod_start;
  logic [31:0]     mod_x_high, mod_x_low, mod_z_high, mod_z_low;
  logic            mod_valid = 1'b0;
  logic [31:0]     mod_high = '0, mod_low = '0;

  logic [NREQ-1:0] req_valid2 = '0;
  logic [NREQ-1:0] req_ready2, rsp_valid2;
  logic [31:0]     rsp_high2, rsp_low2;
  logic            rsp_error2, mod_start2;
  logic [31:0]     mod_x_high2, mod_x_low2, mod_z_high2, mod_z_low2;
  logic            mod_valid2 = 1'b0;
  logic [31:0]     mod_high2 = '0, mod_low2 = '0;

  rans_mod_scheduler #(.NREQ(NREQ), .TIMEOUT(255)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x_high(req_x_high), .req_x_low(req_x_low),
    .req_z_high(req_z_high), .req_z_low(req_z_low),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_high(rsp_high), .rsp_low(rsp_low), .rsp_error(rsp_error),
    .mod_start(mod_start),
    .mod_x_high(mod_x_high), .mod_x_low(mod_x_low),
    .mod_z_high(mod_z_high), .mod_z_low(mod_z_low),
    .mod_valid(mod_valid), .mod_high(mod_high), .mod_low(mod_low)
  );

  rans_mod_scheduler #(.NREQ(NREQ), .TIMEOUT(TO2)) dut_to (
    .clock(clock), .reset(reset),
    .req_valid(req_valid2), .req_ready(req_ready2),
    .req_x_high(req_x_high), .req_x_low(req_x_low),
    .req_z_high(req_z_high), .req_z_low(req_z_low),
    .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready),
    .rsp_high(rsp_high2), .rsp_low(rsp_low2), .rsp_error(rsp_error2),
    .mod_start(mod_start2),
    .mod_x_high(mod_x_high2), .mod_x_low(mod_x_low2),
    .mod_z_high(mod_z_high2), .mod_z_low(mod_z_low2),
    .mod_valid(mod_valid2), .mod_high(mod_high2), .mod_low(mod_low2)
  );

  // Behavioural modulo unit: mod_valid LAT cycles after the start strobe.
  logic        unit_busy = 1'b0;
  int          unit_cnt  = 0;
  logic [63:0] unit_x = '0, unit_z = '0;
  always @(posedge clock) begin
    mod_valid <= 1'b0;
    if (reset) begin
      unit_busy <= 1'b0;
      unit_cnt  <= 0;
    end else if (mod_start) begin
      unit_busy <= 1'b1;
      unit_cnt  <= 1;
      unit_x    <= {mod_x_high, mod_x_low};
      unit_z    <= {mod_z_high, mod_z_low};
    end else if (unit_busy) begin
      if (unit_cnt == LAT - 1) begin
        unit_busy             <= 1'b0;
        mod_valid             <= 1'b1;
        {mod_high, mod_low}   <= unit_x % unit_z;
      end else begin
        unit_cnt <= unit_cnt + 1;
      end
    end
  end

  int n_start = 0;
  always @(posedge clock) if (mod_start) n_start++;

  typedef struct {
    int          idx;
    logic [31:0] high;
    logic [31:0] low;
    logic        err;
  } exp_t;
  exp_t sb[$];

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [31:0] xh, xl, zh, zl);
    req_x_high[i*32 +: 32] = xh;
    req_x_low[i*32 +: 32]  = xl;
    req_z_high[i*32 +: 32] = zh;
    req_z_low[i*32 +: 32]  = zl;
  endtask

  task automatic wait_accept(input int budget, output int t);
    bit found;
    found = 1'b0;
    t     = cyc;
    for (int k = 0; k < budget && !found; k++) begin
      #1;
      if (|req_ready) begin
        found = 1'b1;
        t     = cyc;
      end else begin
        @(negedge clock);
      end
    end
    chk("accept_seen", 64'(found), 64'd1);
  endtask

  task automatic wait_rsp(input int budget, output int t);
    bit   found;
    exp_t e;
    found = 1'b0;
    t     = cyc;
    for (int k = 0; k < budget && !found; k++) begin
      #1;
      if (|rsp_valid) begin
        found = 1'b1;
        t     = cyc;
      end else begin
        @(negedge clock);
      end
    end
    chk("rsp_seen", 64'(found), 64'd1);
    if (found) begin
      chk("sb_nonempty", 64'(sb.size() > 0), 64'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("rsp_owner", 64'(rsp_valid), 64'd1 << e.idx);
        chk("rsp_high", 64'(rsp_high), 64'(e.high));
        chk("rsp_low", 64'(rsp_low), 64'(e.low));
        chk("rsp_error", 64'(rsp_error), 64'(e.err));
      end
    end
  endtask

  task automatic do_single(input int who, input logic [31:0] xh, xl, zh, zl,
                           input logic [31:0] exp_h, exp_l, input logic exp_err,
                           input int exp_lat, input string tag);
    int ta, tr;
    set_req(who, xh, xl, zh, zl);
    req_valid[who] = 1'b1;
    sb.push_back('{who, exp_h, exp_l, exp_err});
    wait_accept(20, ta);
    chk({tag, "_grant"}, 64'(req_ready), 64'd1 << who);
    @(negedge clock);
    req_valid[who] = 1'b0;
    if (!exp_err) begin
      chk({tag, "_start"}, 64'(mod_start), 64'd1);
      chk({tag, "_op_x"}, {mod_x_high, mod_x_low}, {xh, xl});
      chk({tag, "_op_z"}, {mod_z_high, mod_z_low}, {zh, zl});
    end else begin
      chk({tag, "_no_start"}, 64'(mod_start), 64'd0);
    end
    wait_rsp(exp_lat + 10, tr);
    chk({tag, "_latency"}, 64'(tr - ta), 64'(exp_lat));
  endtask

  int ta, tr, g, nst;
  bit found;

  initial begin
    // Reset state
    repeat (3) @(negedge clock);
    reset = 1'b0;
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_data", {rsp_high, rsp_low}, 64'd0);
    chk("rst_rsp_error", 64'(rsp_error), 64'd0);
    chk("rst_mod_start", 64'(mod_start), 64'd0);
    chk("rst_mod_ops", {mod_x_high, mod_x_low ^ mod_z_low, mod_z_high}, 96'd0);

    // Single jobs, including 64-bit operands
    do_single(1, 32'd0, 32'd100, 32'd0, 32'd7, 32'd0, 32'd2, 1'b0, LAT + 2, "single");
    do_single(0, 32'd6144, 32'd0, 32'd0, 32'd3, 32'd0, 32'd0, 1'b0, LAT + 2, "large_a");
    do_single(0, 32'd1, 32'd5, 32'd0, 32'd10, 32'd0, 32'd1, 1'b0, LAT + 2, "large_b");
    do_single(2, 32'd7, 32'd16, 32'd3, 32'd0, 32'd1, 32'd16, 1'b0, LAT + 2, "large_c");

    // Round robin with all requesters valid from reset
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < NREQ; i++) set_req(i, 32'd0, 32'(1000 + i), 32'd0, 32'(7 + i));
    req_valid = '1;
    for (int n = 0; n < 5; n++) begin
      g = n % NREQ;
      wait_accept(20, ta);
      chk("rr_grant", 64'(req_ready), 64'd1 << g);
      if (n > 0) chk("rr_back_to_back", 64'(ta - tr), 64'd1);
      if (n == 4) sb.push_back('{0, 32'd0, 32'(2000 % 7), 1'b0});
      else        sb.push_back('{g, 32'd0, 32'((1000 + g) % (7 + g)), 1'b0});
      @(negedge clock);
      chk("rr_pulse", 64'(req_ready), 64'd0);
      if (n == 0) set_req(0, 32'd0, 32'd2000, 32'd0, 32'd7);
      else        req_valid[g] = 1'b0;
      wait_rsp(LAT + 10, tr);
    end

    // Zero divisor is answered locally
    nst = n_start;
    do_single(2, 32'd0, 32'd123, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1, "zero");
    repeat (3) @(negedge clock);
    chk("zero_unit_unused", 64'(n_start), 64'(nst));

    // Response stall, then reset in RESP
    rsp_ready = '0;
    set_req(3, 32'd0, 32'd50, 32'd0, 32'd6);
    req_valid[3] = 1'b1;
    sb.push_back('{3, 32'd0, 32'd2, 1'b0});
    wait_accept(20, ta);
    @(negedge clock);
    req_valid[3] = 1'b0;
    wait_rsp(LAT + 10, tr);
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      chk("stall_valid", 64'(rsp_valid), 64'b1000);
      chk("stall_low", 64'(rsp_low), 64'd2);
    end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("midrst_rsp_data", {rsp_high, rsp_low}, 64'd0);
    chk("midrst_mod_ops", {mod_x_low, mod_z_low}, 64'd0);
    chk("midrst_mod_start", 64'(mod_start), 64'd0);
    rsp_ready = '1;
    set_req(0, 32'd0, 32'd77, 32'd0, 32'd10);
    set_req(3, 32'd0, 32'd50, 32'd0, 32'd6);
    req_valid = 4'b1001;
    sb.push_back('{0, 32'd0, 32'd7, 1'b0});
    sb.push_back('{3, 32'd0, 32'd2, 1'b0});
    wait_accept(20, ta);
    chk("postrst_ptr_grant", 64'(req_ready), 64'b0001);
    @(negedge clock);
    req_valid[0] = 1'b0;
    wait_rsp(LAT + 10, tr);
    wait_accept(20, ta);
    chk("postrst_second_grant", 64'(req_ready), 64'b1000);
    @(negedge clock);
    req_valid[3] = 1'b0;
    wait_rsp(LAT + 10, tr);

    // Watchdog on the short-timeout instance
    set_req(1, 32'd0, 32'd100, 32'd0, 32'd7);
    req_valid2[1] = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      #1;
      if (|req_ready2) begin found = 1'b1; ta = cyc; end
      else @(negedge clock);
    end
    chk("to_accept_seen", 64'(found), 64'd1);
    chk("to_grant", 64'(req_ready2), 64'b0010);
    @(negedge clock);
    req_valid2[1] = 1'b0;
    chk("to_start", 64'(mod_start2), 64'd1);
    found = 1'b0;
    for (int k = 0; k < TO2 + 10 && !found; k++) begin
      #1;
      if (|rsp_valid2) begin found = 1'b1; tr = cyc; end
      else @(negedge clock);
    end
    chk("to_rsp_seen", 64'(found), 64'd1);
    chk("to_latency", 64'(tr - ta), 64'(TO2 + 2));
    chk("to_owner", 64'(rsp_valid2), 64'b0010);
    chk("to_error", 64'(rsp_error2), 64'd1);
    chk("to_data", {rsp_high2, rsp_low2}, 64'd0);
    @(negedge clock);
    mod_valid2 = 1'b1;
    mod_low2   = 32'd99;
    @(negedge clock);
    mod_valid2 = 1'b0;
    repeat (2) @(negedge clock);
    chk("late_valid_ignored", 64'(rsp_valid2), 64'd0);
    req_valid2[1] = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      #1;
      if (|req_ready2) begin found = 1'b1; ta = cyc; end
      else @(negedge clock);
    end
    chk("to2_accept_seen", 64'(found), 64'd1);
    @(negedge clock);
    req_valid2[1] = 1'b0;
    chk("to2_start", 64'(mod_start2), 64'd1);
    repeat (3) @(negedge clock);
    mod_valid2 = 1'b1;
    mod_high2  = 32'd0;
    mod_low2   = 32'd2;
    @(negedge clock);
    mod_valid2 = 1'b0;
    #1;
    chk("to2_latency", 64'(cyc - ta), 64'd5);
    chk("to2_owner", 64'(rsp_valid2), 64'b0010);
    chk("to2_low", 64'(rsp_low2), 64'd2);
    chk("to2_error", 64'(rsp_error2), 64'd0);

    repeat (3) @(negedge clock);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
